// File: rtl/mips_pkg.sv
// Shared constants and forward-select encoding for the MIPS decode-stage register bank.
package mips_pkg;

   localparam int unsigned DATA_W   = 16;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_REGS = 32'(1) << ADDR_W;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_EX  = 2'b01,
      FWD_DM  = 2'b10,
      FWD_WB  = 2'b11
   } fwd_sel_t;

endpackage

// File: rtl/mips_register_bank_fwd_mux4.sv
// 4:1 operand forwarding mux: register read or EX/DM/WB result.
module fwd_mux4 #(
   parameter int unsigned DATA_W = mips_pkg::DATA_W
) (
   input  mips_pkg::fwd_sel_t sel,
   input  logic [DATA_W-1:0]  reg_val,
   input  logic [DATA_W-1:0]  ans_ex,
   input  logic [DATA_W-1:0]  ans_dm,
   input  logic [DATA_W-1:0]  ans_wb,
   output logic [DATA_W-1:0]  y_c
);
   import mips_pkg::*;

   always_comb begin
      y_c = reg_val;
      case (sel)
         FWD_REG: y_c = reg_val;
         FWD_EX:  y_c = ans_ex;
         FWD_DM:  y_c = ans_dm;
         FWD_WB:  y_c = ans_wb;
         default: y_c = reg_val;
      endcase
   end

endmodule

// File: rtl/mips_register_bank.sv
// 32 x 16 register file with forwarded, registered A/B operands.
// Optional REG_ZERO_HARDWIRED_EN: register 0 reads 0 and ignores writes.
module mips_register_bank #(
   parameter int unsigned DATA_W = mips_pkg::DATA_W,
   parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] RA,
   input  logic [ADDR_W-1:0] RB,
   input  logic [ADDR_W-1:0] RW_dm,
   input  logic [DATA_W-1:0] ans_ex,
   input  logic [DATA_W-1:0] ans_dm,
   input  logic [DATA_W-1:0] ans_wb,
   input  logic [DATA_W-1:0] imm,
   input  logic [1:0]        mux_sel_A,
   input  logic [1:0]        mux_sel_B,
   input  logic              imm_sel,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B
);
   import mips_pkg::*;

   localparam int unsigned N_REGS = 32'(1) << ADDR_W;

   logic [DATA_W-1:0] regs_q [N_REGS];
   logic [DATA_W-1:0] regs_d [N_REGS];
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] fwd_a_c, fwd_b_c;

   fwd_mux4 #(.DATA_W(DATA_W)) u_fwd_a (
      .sel     (fwd_sel_t'(mux_sel_A)),
      .reg_val (regs_q[RA]),
      .ans_ex  (ans_ex),
      .ans_dm  (ans_dm),
      .ans_wb  (ans_wb),
      .y_c     (fwd_a_c)
   );

   fwd_mux4 #(.DATA_W(DATA_W)) u_fwd_b (
      .sel     (fwd_sel_t'(mux_sel_B)),
      .reg_val (regs_q[RB]),
      .ans_ex  (ans_ex),
      .ans_dm  (ans_dm),
      .ans_wb  (ans_wb),
      .y_c     (fwd_b_c)
   );

   // Reads above use regs_q, so a same-cycle write is only seen via ans_dm.
   always_comb begin
      regs_d        = regs_q;
      regs_d[RW_dm] = ans_dm;
`ifdef REG_ZERO_HARDWIRED_EN
      regs_d[0]     = '0;
`endif
      a_d = fwd_a_c;
      b_d = imm_sel ? imm : fwd_b_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(N_REGS); i++) regs_q[i] <= '0;
         a_q <= '0;
         b_q <= '0;
      end else begin
         regs_q <= regs_d;
         a_q    <= a_d;
         b_q    <= b_d;
      end
   end

   assign A = a_q;
   assign B = b_q;

endmodule

// File: tb/tb_mips_register_bank.sv
// Self-checking bench for mips_register_bank: directed plan plus random traffic vs. an array model.
module tb_mips_register_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  ra, rb, rw;
   logic [15:0] ans_ex, ans_dm, ans_wb, imm;
   logic [1:0]  sel_a, sel_b;
   logic        imm_sel;
   logic [15:0] a_o, b_o;

   int tests = 0;
   int fails = 0;

   logic [15:0] mreg [32];
   logic [15:0] exp_a = 16'h0;
   logic [15:0] exp_b = 16'h0;

   mips_register_bank dut (
      .clk       (clk),
      .rst       (rst),
      .RA        (ra),
      .RB        (rb),
      .RW_dm     (rw),
      .ans_ex    (ans_ex),
      .ans_dm    (ans_dm),
      .ans_wb    (ans_wb),
      .imm       (imm),
      .mux_sel_A (sel_a),
      .mux_sel_B (sel_b),
      .imm_sel   (imm_sel),
      .A         (a_o),
      .B         (b_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [15:0] fwd(input logic [1:0] s, input logic [15:0] r);
      case (s)
         2'd0:    return r;
         2'd1:    return ans_ex;
         2'd2:    return ans_dm;
         default: return ans_wb;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mreg[i] = 16'h0;
      exp_a = 16'h0;
      exp_b = 16'h0;
   endtask

   // Predict from the pre-edge array, then apply the write, then clock and compare.
   task automatic step(input string tag);
      logic [15:0] na, nb;
      na = fwd(sel_a, mreg[ra]);
      nb = imm_sel ? imm : fwd(sel_b, mreg[rb]);
`ifdef REG_ZERO_HARDWIRED_EN
      if (rw != 5'd0) mreg[rw] = ans_dm;
`else
      mreg[rw] = ans_dm;
`endif
      exp_a = na;
      exp_b = nb;
      @(posedge clk);
      #1;
      chk({tag, "_A"}, a_o, exp_a);
      chk({tag, "_B"}, b_o, exp_b);
   endtask

   task automatic randomize_inputs();
      ra      = 5'($urandom_range(0, 31));
      rb      = 5'($urandom_range(0, 31));
      rw      = 5'($urandom_range(0, 31));
      ans_ex  = 16'($urandom);
      ans_dm  = 16'($urandom);
      ans_wb  = 16'($urandom);
      imm     = 16'($urandom);
      sel_a   = 2'($urandom_range(0, 3));
      sel_b   = 2'($urandom_range(0, 3));
      imm_sel = 1'($urandom_range(0, 1));
   endtask

   initial begin
      // Reset: outputs zero immediately and while rst stays high
      rst = 1'b1;
      ra = 5'd0; rb = 5'd0; rw = 5'd7;
      ans_ex = 16'hC000; ans_dm = 16'hD000; ans_wb = 16'hE000; imm = 16'hFFFF;
      sel_a = 2'b00; sel_b = 2'b00; imm_sel = 1'b0;
      model_reset();
      #1;
      chk("reset_imm_A", a_o, 16'h0000);
      chk("reset_imm_B", b_o, 16'h0000);
      sel_a = 2'b11; sel_b = 2'b01; imm_sel = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("reset_hold_A", a_o, 16'h0000);
         chk("reset_hold_B", b_o, 16'h0000);
      end
      @(negedge clk);
      rst = 1'b0;

      // Write regs[7] then read it back through select 00
      rw = 5'd7; ans_dm = 16'hD000; sel_a = 2'b00; sel_b = 2'b00; imm_sel = 1'b0;
      step("wr7");
      ra = 5'd7; rb = 5'd7; rw = 5'd9;
      step("rd7");
      chk("rd7_A_val", a_o, 16'hD000);
      chk("rd7_B_val", b_o, 16'hD000);

      // Forwarding paths
      sel_a = 2'b10; sel_b = 2'b01;
      step("fwd1");
      chk("fwd1_A_val", a_o, 16'hD000);
      chk("fwd1_B_val", b_o, 16'hC000);
      sel_a = 2'b11; sel_b = 2'b00;
      step("fwd2");
      chk("fwd2_A_val", a_o, 16'hE000);
      chk("fwd2_B_val", b_o, 16'hD000);

      // Immediate overrides every B select; A unchanged
      imm_sel = 1'b1; imm = 16'hFFFF;
      for (int s = 0; s < 4; s++) begin
         sel_b = 2'(s);
         step("imm");
         chk("imm_B_val", b_o, 16'hFFFF);
         chk("imm_A_val", a_o, 16'hE000);
      end
      imm_sel = 1'b0;

      // Read-before-write on the same index
      ra = 5'd5; rw = 5'd5; sel_a = 2'b00; ans_dm = 16'h1234;
      step("rbw1");
      chk("rbw1_A_val", a_o, 16'h0000);
      step("rbw2");
      chk("rbw2_A_val", a_o, 16'h1234);

      // Register 0 behaviour depends on the build option
      rw = 5'd0; ans_dm = 16'hD000;
      step("r0wr");
      ra = 5'd0; rw = 5'd1;
      step("r0rd");
`ifdef REG_ZERO_HARDWIRED_EN
      chk("r0_A_val", a_o, 16'h0000);
`else
      chk("r0_A_val", a_o, 16'hD000);
`endif

      // Random traffic against the model
      for (int n = 0; n < 300; n++) begin
         randomize_inputs();
         step("rand");
      end

      // Reset mid-operation discards the pending write and clears the array
      randomize_inputs();
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      chk("midrst_A", a_o, 16'h0000);
      chk("midrst_B", b_o, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 32; n++) begin
         ra = 5'(n); rb = 5'(31 - n); rw = 5'(n);
         sel_a = 2'b00; sel_b = 2'b00; imm_sel = 1'b0;
         ans_dm = 16'($urandom);
         step("postrst");
      end
      for (int n = 0; n < 200; n++) begin
         randomize_inputs();
         step("rand2");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
